// File: rtl/nibble_mult_seq.sv
// Sequential N x N unsigned multiplier built around one external 4x4 lookup
// multiplier. Each cycle in CALC one nibble pair goes out on lut_a/lut_b, and the
// lookup product comes back the same cycle. The product is shifted into place
// and added to a 2N-bit accumulator.
module nibble_mult_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] y,
    output logic           busy,
    output logic [3:0]     lut_a,
    output logic [3:0]     lut_b,
    input  logic [7:0]     lut_y
);

    localparam int NIB = N / 4;
    // Keep the index registers at least one bit wide so that N=4 still elaborates.
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] y_q, y_d;
    logic [IW-1:0]  i_q, i_d, j_q, j_d;
    logic [N-1:0]   opa_q, opa_d, opb_q, opb_d;

    logic [N-1:0]   opa_sh, opb_sh;
    logic [IW:0]    pos;
    logic [2*N-1:0] lut_ext, term;
    logic           calc, last;

    // Nibble select and shifted partial product for the current (i, j) pair
    always_comb begin
        calc    = (state_q == CALC);
        opa_sh  = opa_q >> {i_q, 2'b00};
        opb_sh  = opb_q >> {j_q, 2'b00};
        lut_a   = calc ? opa_sh[3:0] : 4'h0;
        lut_b   = calc ? opb_sh[3:0] : 4'h0;
        lut_ext = '0;
        lut_ext[7:0] = lut_y;
        pos     = {1'b0, i_q} + {1'b0, j_q};
        term    = lut_ext << {pos, 2'b00};
        last    = (i_q == LAST) && (j_q == LAST);
    end

    // Handshake outputs decode straight from state, so an async reset clears them at once
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == CALC) || (state_q == DONE);
        y         = y_q;
    end

    // Next-state logic: accept, step through nibble pairs, hold the result until it is taken
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        y_d     = y_q;
        i_d     = i_q;
        j_d     = j_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + term;
                if (j_q == LAST) begin
                    j_d = '0;
                    i_d = i_q + IW'(1);
                end else begin
                    j_d = j_q + IW'(1);
                end
                // y only changes on entry to DONE, so it holds the previous result during CALC
                if (last) begin
                    y_d     = acc_q + term;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            y_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            i_q     <= i_d;
            j_q     <= j_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

endmodule

// File: tb/tb_nibble_mult_seq.sv
// Directed bench for nibble_mult_seq: one N=8 instance for protocol and timing
// scenarios, one N=16 instance for the wide corner case and a random product sweep.
module tb_nibble_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // N=8 instance
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8, lut_y8;
    logic [15:0] y8;
    logic [3:0]  lut_a8, lut_b8;
    assign lut_y8 = {4'h0, lut_a8} * {4'h0, lut_b8};

    nibble_mult_seq #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .busy(busy8), .lut_a(lut_a8), .lut_b(lut_b8), .lut_y(lut_y8)
    );

    // N=16 instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] y16;
    logic [7:0]  lut_y16;
    logic [3:0]  lut_a16, lut_b16;
    assign lut_y16 = {4'h0, lut_a16} * {4'h0, lut_b16};

    nibble_mult_seq #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .y(y16), .busy(busy16), .lut_a(lut_a16), .lut_b(lut_b16), .lut_y(lut_y16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [7:0] av, input logic [7:0] bv);
        in_valid8 = 1'b1; a8 = av; b8 = bv;
        tick();
        in_valid8 = 1'b0;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (!out_valid8 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || y8 !== 16'h0 ||
            lut_a8 !== 4'h0 || lut_b8 !== 4'h0) begin
            n_err++;
            $display("FAIL reset8: rdy=%b ov=%b busy=%b y=%h la=%h lb=%h, want 1 0 0 0000 0 0",
                     in_ready8, out_valid8, busy8, y8, lut_a8, lut_b8);
        end
        n_cmp++;
        if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || busy16 !== 1'b0 || y16 !== 32'h0) begin
            n_err++;
            $display("FAIL reset16: rdy=%b ov=%b busy=%b y=%h, want 1 0 0 00000000",
                     in_ready16, out_valid16, busy16, y16);
        end
    endtask

    task automatic test_full_scale();
        int cyc;
        out_ready8 = 1'b1;
        start8(8'hFF, 8'hFF);
        n_cmp++;
        if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
            n_err++;
            $display("FAIL ff_calc_flags: busy=%b rdy=%b, want 1 0", busy8, in_ready8);
        end
        wait_done8(cyc);
        n_cmp++;
        if (cyc !== 4) begin
            n_err++;
            $display("FAIL ff_latency: got %0d cycles, want 4", cyc);
        end
        n_cmp++;
        if (y8 !== 16'hFE01) begin
            n_err++;
            $display("FAIL ff_result: y=%h, want fe01", y8);
        end
        tick();
        n_cmp++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || y8 !== 16'hFE01) begin
            n_err++;
            $display("FAIL ff_release: rdy=%b ov=%b busy=%b y=%h, want 1 0 0 fe01",
                     in_ready8, out_valid8, busy8, y8);
        end
    endtask

    task automatic test_zero_operand();
        logic [3:0] exp_a [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
        logic [3:0] exp_b [4] = '{4'h7, 4'hA, 4'h7, 4'hA};
        out_ready8 = 1'b1;
        start8(8'h00, 8'hA7);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (lut_a8 !== exp_a[k] || lut_b8 !== exp_b[k] || out_valid8 !== 1'b0) begin
                n_err++;
                $display("FAIL zero_lut_seq[%0d]: (%h,%h) ov=%b, want (%h,%h) ov=0",
                         k, lut_a8, lut_b8, out_valid8, exp_a[k], exp_b[k]);
            end
            tick();
        end
        n_cmp++;
        if (out_valid8 !== 1'b1 || y8 !== 16'h0000 || lut_a8 !== 4'h0 || lut_b8 !== 4'h0) begin
            n_err++;
            $display("FAIL zero_result: ov=%b y=%h la=%h lb=%h, want 1 0000 0 0",
                     out_valid8, y8, lut_a8, lut_b8);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready8 = 1'b0;
        start8(8'h3C, 8'h5A);
        wait_done8(cyc);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (out_valid8 !== 1'b1 || y8 !== 16'h1518 || in_ready8 !== 1'b0 || busy8 !== 1'b1) begin
                n_err++;
                $display("FAIL hold[%0d]: ov=%b y=%h rdy=%b busy=%b, want 1 1518 0 1",
                         k, out_valid8, y8, in_ready8, busy8);
            end
            tick();
        end
        out_ready8 = 1'b1;
        tick();
        n_cmp++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release: ov=%b rdy=%b, want 0 1", out_valid8, in_ready8);
        end
    endtask

    task automatic test_ignore_in_calc();
        int cyc;
        out_ready8 = 1'b1;
        start8(8'h12, 8'h34);
        in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        n_cmp++;
        if (in_ready8 !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_rdy: rdy=%b, want 0", in_ready8);
        end
        tick();
        in_valid8 = 1'b0;
        wait_done8(cyc);
        n_cmp++;
        if (y8 !== 16'h03A8 || cyc !== 3) begin
            n_err++;
            $display("FAIL ignore_result: y=%h after %0d more cycles, want 03a8 after 3", y8, cyc);
        end
        tick();
    endtask

    task automatic test_reset_mid_calc();
        int cyc;
        out_ready8 = 1'b1;
        start8(8'h77, 8'h77);
        tick();
        n_cmp++;
        if (busy8 !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: busy=%b, want 1", busy8);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0 || lut_a8 !== 4'h0) begin
            n_err++;
            $display("FAIL midrst_async: ov=%b rdy=%b busy=%b la=%h, want 0 1 0 0",
                     out_valid8, in_ready8, busy8, lut_a8);
        end
        tick();
        rst = 1'b0;
        tick();
        start8(8'h09, 8'h09);
        wait_done8(cyc);
        n_cmp++;
        if (y8 !== 16'h0051 || cyc !== 4) begin
            n_err++;
            $display("FAIL midrst_next: y=%h lat=%0d, want 0051 lat 4", y8, cyc);
        end
        tick();
    endtask

    task automatic mult16(input logic [15:0] av, input logic [15:0] bv, output int cyc);
        in_valid16 = 1'b1; a16 = av; b16 = bv;
        tick();
        in_valid16 = 1'b0;
        cyc = 0;
        while (!out_valid16 && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_wide();
        int cyc;
        logic [15:0] ra, rb;
        logic [31:0] exp;
        int bad;
        out_ready16 = 1'b1;
        mult16(16'hFFFF, 16'hFFFF, cyc);
        n_cmp++;
        if (cyc !== 16 || y16 !== 32'hFFFE0001) begin
            n_err++;
            $display("FAIL wide_ffff: y=%h lat=%0d, want fffe0001 lat 16", y16, cyc);
        end
        tick();
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            exp = {16'h0, ra} * {16'h0, rb};
            mult16(ra, rb, cyc);
            n_cmp++;
            if (y16 !== exp || cyc !== 16) begin
                n_err++;
                bad++;
                if (bad < 5)
                    $display("FAIL wide_rand[%0d]: %h*%h y=%h lat=%0d, want %h lat 16",
                             k, ra, rb, y16, cyc, exp);
            end
            tick();
        end
    endtask

    initial begin
        in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_full_scale();
        test_zero_operand();
        test_backpressure();
        test_ignore_in_calc();
        test_reset_mid_calc();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
